// File: rtl/mdma_32bx2048_32bwe_ram_pkg.sv
// SECDED helpers for the 2048x32 mdma RAM: 32 data bits, 6 Hamming bits, 1 overall parity.
// Codeword layout is {parity, hamming[5:0], data[31:0]}; data bits map to the non-power-of-two Hamming positions.
package mdma_ram_ecc_pkg;
  localparam int DEPTH = 2048;
  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int CW    = 7;
  localparam int CWW   = DW + CW;

  typedef logic [CWW-1:0] codeword_t;
  typedef logic [5:0]     syndrome_t;
  typedef enum logic { INIT, RUN } state_t;

  // Hamming position (3,5,6,7,9,...) occupied by data bit idx.
  function automatic syndrome_t data_pos(input int idx);
    syndrome_t p;
    int        n;
    p = '0;
    n = 0;
    for (int pos = 3; pos < 64; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (n == idx) p = syndrome_t'(pos);
        n++;
      end
    end
    return p;
  endfunction

  function automatic codeword_t ecc_enc(input logic [DW-1:0] d);
    syndrome_t h;
    h = '0;
    for (int i = 0; i < DW; i++) begin
      if (d[i]) h ^= data_pos(i);
    end
    return {^{h, d}, h, d};
  endfunction

  function automatic syndrome_t ecc_syndrome(input codeword_t cw);
    syndrome_t s;
    s = cw[DW+5:DW];
    for (int i = 0; i < DW; i++) begin
      if (cw[i]) s ^= data_pos(i);
    end
    return s;
  endfunction
endpackage

// File: rtl/mdma_32bx2048_32bwe_ram_if.sv
// Write/read port bundle between the mdma engine (m) and the RAM responder (s).
// Optional error-injection inputs exist only when MDMA_RAM_ERR_INJECT_EN is defined.
interface mdma_32bx2048_32bwe_ram_if;
  import mdma_ram_ecc_pkg::*;

  logic [AW-1:0] wadr;
  logic          wen;
  logic [DW-1:0] wdat;
  logic          ren;
  logic [AW-1:0] radr;
  logic [DW-1:0] rdat;
  logic          rsbe;
  logic          rdbe;
  logic          init_done;
`ifdef MDMA_RAM_ERR_INJECT_EN
  logic          inj_sbe;
  logic          inj_dbe;
`endif

  modport m (
`ifdef MDMA_RAM_ERR_INJECT_EN
    output inj_sbe, output inj_dbe,
`endif
    output wadr, output wen, output wdat, output ren, output radr,
    input  rdat, input  rsbe, input  rdbe, input  init_done
  );

  modport s (
`ifdef MDMA_RAM_ERR_INJECT_EN
    input  inj_sbe, input  inj_dbe,
`endif
    input  wadr, input  wen, input  wdat, input  ren, input  radr,
    output rdat, output rsbe, output rdbe, output init_done
  );
endinterface

// File: rtl/mdma_secded_dec.sv
// Combinational SECDED decode: corrects any single-bit error, flags double-bit errors.
module mdma_secded_dec
  import mdma_ram_ecc_pkg::*;
(
  input  codeword_t     cw,
  output logic [DW-1:0] data,
  output logic          sbe,
  output logic          dbe
);
  syndrome_t syn;
  logic      perr;

  always_comb begin
    syn  = ecc_syndrome(cw);
    perr = ^cw;
    data = cw[DW-1:0];
    sbe  = 1'b0;
    dbe  = 1'b0;
    if (perr) begin
      // Syndrome pointing at a check or parity bit leaves the data untouched.
      sbe = 1'b1;
      for (int i = 0; i < DW; i++) begin
        if (data_pos(i) == syn) data[i] = ~cw[i];
      end
    end else if (syn != '0) begin
      dbe = 1'b1;
    end
  end
endmodule

// File: rtl/mdma_32bx2048_32bwe_ram.sv
// 2048x32 SECDED simple-dual-port RAM responder with post-reset zero scrub, 2-cycle read latency.
// MDMA_RAM_ERR_INJECT_EN adds inj_sbe/inj_dbe write-side codeword corruption.
module mdma_32bx2048_32bwe_ram
  import mdma_ram_ecc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  mdma_32bx2048_32bwe_ram_if.s     bus
);
  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] scrub_adr;
  logic          init_done_q;

  codeword_t     mem [DEPTH];
  codeword_t     enc_cw;
  codeword_t     wr_cw;
  logic [AW-1:0] wr_adr;
  logic          wr_en;

  codeword_t     rd_cw1;
  logic          rd_vld1;
  logic [DW-1:0] dec_data;
  logic          dec_sbe;
  logic          dec_dbe;
  logic [DW-1:0] rdat_q;
  logic          rsbe_q;
  logic          rdbe_q;

`ifdef MDMA_RAM_ERR_INJECT_EN
  assign enc_cw = ecc_enc(bus.wdat) ^ (bus.inj_dbe ? CWW'(3) : (bus.inj_sbe ? CWW'(1) : CWW'(0)));
`else
  assign enc_cw = ecc_enc(bus.wdat);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      scrub_adr   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      init_done_q <= (state == RUN);
      if (state == INIT) scrub_adr <= scrub_adr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_adr    = bus.wadr;
    wr_cw     = enc_cw;
    case (state)
      INIT: begin
        wr_en  = 1'b1;
        wr_adr = scrub_adr;
        wr_cw  = '0;
        if (scrub_adr == AW'(DEPTH - 1)) state_nxt = RUN;
      end
      RUN: begin
        wr_en = bus.wen;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Nonblocking array update gives read-first behaviour on same-address collisions.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_adr] <= wr_cw;
    if (bus.ren) rd_cw1 <= mem[bus.radr];
  end

  mdma_secded_dec u_dec (
    .cw   (rd_cw1),
    .data (dec_data),
    .sbe  (dec_sbe),
    .dbe  (dec_dbe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld1 <= 1'b0;
      rdat_q  <= '0;
      rsbe_q  <= 1'b0;
      rdbe_q  <= 1'b0;
    end else begin
      rd_vld1 <= (state == RUN) && bus.ren;
      rsbe_q  <= rd_vld1 && dec_sbe;
      rdbe_q  <= rd_vld1 && dec_dbe;
      if (rd_vld1) rdat_q <= dec_data;
    end
  end

  assign bus.rdat      = rdat_q;
  assign bus.rsbe      = rsbe_q;
  assign bus.rdbe      = rdbe_q;
  assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_mdma_32bx2048_32bwe_ram.sv
// Directed bench for the SECDED RAM responder: scrub, read/write, pipelining, collisions, reset, decode.
module tb_mdma_32bx2048_32bwe_ram;
  import mdma_ram_ecc_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mdma_32bx2048_32bwe_ram_if bus ();

  mdma_32bx2048_32bwe_ram dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  codeword_t     t_cw;
  logic [DW-1:0] t_data;
  logic          t_sbe;
  logic          t_dbe;

  mdma_secded_dec u_dec_chk (
    .cw   (t_cw),
    .data (t_data),
    .sbe  (t_sbe),
    .dbe  (t_dbe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wen  = 1'b1;
    bus.wadr = a;
    bus.wdat = d;
    tick;
    bus.wen  = 1'b0;
  endtask

  task automatic read_word(input logic [AW-1:0] a);
    bus.ren  = 1'b1;
    bus.radr = a;
    tick;
    bus.ren  = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    int cnt;
    rst_n    = 1'b0;
    bus.wen  = 1'b0;
    bus.ren  = 1'b0;
    bus.wadr = '0;
    bus.radr = '0;
    bus.wdat = '0;
`ifdef MDMA_RAM_ERR_INJECT_EN
    bus.inj_sbe = 1'b0;
    bus.inj_dbe = 1'b0;
`endif
    repeat (3) tick;
    total++; if (bus.rdat !== 32'h0) begin bad++; $display("FAIL rst_rdat got=%h exp=0", bus.rdat); end
    total++; if (bus.rsbe !== 1'b0) begin bad++; $display("FAIL rst_rsbe got=%b exp=0", bus.rsbe); end
    total++; if (bus.rdbe !== 1'b0) begin bad++; $display("FAIL rst_rdbe got=%b exp=0", bus.rdbe); end
    total++; if (bus.init_done !== 1'b0) begin bad++; $display("FAIL rst_init_done got=%b exp=0", bus.init_done); end
    rst_n    = 1'b1;
    bus.wen  = 1'b1;
    bus.wadr = 11'h005;
    bus.wdat = 32'hFFFF_FFFF;
    bus.ren  = 1'b1;
    bus.radr = 11'h005;
    cnt = 0;
    while (bus.init_done !== 1'b1 && cnt < 5000) begin
      tick;
      cnt++;
      if (cnt <= 10) begin
        total++;
        if (bus.rsbe !== 1'b0 || bus.rdbe !== 1'b0 || bus.rdat !== 32'h0) begin
          bad++; $display("FAIL init_ignore cyc=%0d got rdat=%h sbe=%b dbe=%b exp 0/0/0", cnt, bus.rdat, bus.rsbe, bus.rdbe);
        end
      end
      if (cnt == 10) begin
        bus.wen = 1'b0;
        bus.ren = 1'b0;
      end
    end
    total++; if (cnt != 2049) begin bad++; $display("FAIL init_cycles got=%0d exp=2049", cnt); end
    read_word(11'h7FF);
    total++; if (bus.rdat !== 32'h0 || bus.rsbe !== 1'b0 || bus.rdbe !== 1'b0) begin
      bad++; $display("FAIL scrub_7ff got rdat=%h sbe=%b dbe=%b exp 0/0/0", bus.rdat, bus.rsbe, bus.rdbe);
    end
    read_word(11'h005);
    total++; if (bus.rdat !== 32'h0) begin bad++; $display("FAIL init_wen_ignored got=%h exp=0", bus.rdat); end
  endtask

  task automatic test_write_read;
    write_word(11'h123, 32'hDEAD_BEEF);
    bus.ren  = 1'b1;
    bus.radr = 11'h123;
    tick;
    bus.ren  = 1'b0;
    total++; if (bus.rdat !== 32'h0) begin bad++; $display("FAIL wr_early got=%h exp=0", bus.rdat); end
    tick;
    total++; if (bus.rdat !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_rdat got=%h exp=deadbeef", bus.rdat); end
    total++; if (bus.rsbe !== 1'b0 || bus.rdbe !== 1'b0) begin bad++; $display("FAIL wr_flags got=%b%b exp=00", bus.rsbe, bus.rdbe); end
    tick;
    total++; if (bus.rdat !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_hold got=%h exp=deadbeef", bus.rdat); end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] exp_d [4];
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
    for (int i = 0; i < 4; i++) write_word(AW'(i), exp_d[i]);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        bus.ren  = 1'b1;
        bus.radr = AW'(i);
      end else begin
        bus.ren  = 1'b0;
      end
      tick;
      if (i >= 1 && i <= 4) begin
        total++; if (bus.rdat !== exp_d[i-1]) begin bad++; $display("FAIL b2b_%0d got=%h exp=%h", i - 1, bus.rdat, exp_d[i-1]); end
      end
      if (i == 5) begin
        total++; if (bus.rdat !== 32'h44 || bus.rsbe !== 1'b0) begin bad++; $display("FAIL b2b_hold got=%h sbe=%b exp=44/0", bus.rdat, bus.rsbe); end
      end
    end
  endtask

  task automatic test_collision;
    write_word(11'h010, 32'h5);
    bus.wen  = 1'b1;
    bus.wadr = 11'h010;
    bus.wdat = 32'hA5A5_A5A5;
    bus.ren  = 1'b1;
    bus.radr = 11'h010;
    tick;
    bus.wen  = 1'b0;
    bus.ren  = 1'b0;
    tick;
    total++; if (bus.rdat !== 32'h5) begin bad++; $display("FAIL coll_old got=%h exp=5", bus.rdat); end
    read_word(11'h010);
    total++; if (bus.rdat !== 32'hA5A5_A5A5) begin bad++; $display("FAIL coll_new got=%h exp=a5a5a5a5", bus.rdat); end
  endtask

`ifdef MDMA_RAM_ERR_INJECT_EN
  task automatic test_inject;
    bus.inj_sbe = 1'b1;
    write_word(11'h055, 32'hCAFE_F00D);
    bus.inj_sbe = 1'b0;
    bus.ren  = 1'b1;
    bus.radr = 11'h055;
    tick;
    bus.ren  = 1'b0;
    total++; if (bus.rsbe !== 1'b0) begin bad++; $display("FAIL inj_sbe_early got=%b exp=0", bus.rsbe); end
    tick;
    total++; if (bus.rdat !== 32'hCAFE_F00D || bus.rsbe !== 1'b1 || bus.rdbe !== 1'b0) begin
      bad++; $display("FAIL inj_sbe got rdat=%h sbe=%b dbe=%b exp cafef00d/1/0", bus.rdat, bus.rsbe, bus.rdbe);
    end
    tick;
    total++; if (bus.rsbe !== 1'b0) begin bad++; $display("FAIL inj_sbe_pulse got=%b exp=0", bus.rsbe); end
    bus.inj_sbe = 1'b1;
    bus.inj_dbe = 1'b1;
    write_word(11'h055, 32'hCAFE_F00D);
    bus.inj_sbe = 1'b0;
    bus.inj_dbe = 1'b0;
    read_word(11'h055);
    total++; if (bus.rdat !== 32'hCAFE_F00E || bus.rsbe !== 1'b0 || bus.rdbe !== 1'b1) begin
      bad++; $display("FAIL inj_dbe got rdat=%h sbe=%b dbe=%b exp cafef00e/0/1", bus.rdat, bus.rsbe, bus.rdbe);
    end
    tick;
    total++; if (bus.rdbe !== 1'b0) begin bad++; $display("FAIL inj_dbe_pulse got=%b exp=0", bus.rdbe); end
  endtask
`endif

  task automatic test_decoder;
    codeword_t     flip [8];
    logic [DW-1:0] exp_d [8];
    logic [1:0]    exp_f [8];
    flip[0] = 39'h0;                     exp_d[0] = 32'h0;        exp_f[0] = 2'b00;
    flip[1] = 39'h1;                     exp_d[1] = 32'h0;        exp_f[1] = 2'b10;
    flip[2] = 39'h0_8000_0000;           exp_d[2] = 32'h0;        exp_f[2] = 2'b10;
    flip[3] = 39'h1_0000_0000;           exp_d[3] = 32'h0;        exp_f[3] = 2'b10;
    flip[4] = 39'h40_0000_0000;          exp_d[4] = 32'h0;        exp_f[4] = 2'b10;
    flip[5] = 39'h3;                     exp_d[5] = 32'h3;        exp_f[5] = 2'b01;
    flip[6] = 39'h41_0000_0000;          exp_d[6] = 32'h0;        exp_f[6] = 2'b01;
    flip[7] = 39'h0_0010_0020;           exp_d[7] = 32'h0010_0020; exp_f[7] = 2'b01;
    for (int i = 0; i < 8; i++) begin
      t_cw = flip[i];
      #1;
      total++;
      if (t_data !== exp_d[i] || {t_sbe, t_dbe} !== exp_f[i]) begin
        bad++; $display("FAIL dec_%0d got data=%h sbe/dbe=%b%b exp data=%h sbe/dbe=%b", i, t_data, t_sbe, t_dbe, exp_d[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_reset_midway;
    int cnt;
    bus.ren  = 1'b1;
    bus.radr = 11'h123;
    tick;
    tick;
    bus.ren  = 1'b0;
    rst_n    = 1'b0;
    #1;
    total++; if (bus.rdat !== 32'h0 || bus.rsbe !== 1'b0 || bus.rdbe !== 1'b0 || bus.init_done !== 1'b0) begin
      bad++; $display("FAIL mid_rd_rst got rdat=%h sbe=%b dbe=%b done=%b exp 0/0/0/0", bus.rdat, bus.rsbe, bus.rdbe, bus.init_done);
    end
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      total++; if (bus.rdat !== 32'h0 || bus.rsbe !== 1'b0) begin bad++; $display("FAIL mid_rd_stale got rdat=%h sbe=%b exp 0/0", bus.rdat, bus.rsbe); end
    end
    repeat (510) tick;
    total++; if (dut.scrub_adr !== 11'h200) begin bad++; $display("FAIL scrub_pos got=%h exp=200", dut.scrub_adr); end
    rst_n = 1'b0;
    #1;
    total++; if (dut.scrub_adr !== 11'h0 || bus.init_done !== 1'b0) begin
      bad++; $display("FAIL mid_scrub_rst got adr=%h done=%b exp 0/0", dut.scrub_adr, bus.init_done);
    end
    tick;
    rst_n = 1'b1;
    cnt = 0;
    while (bus.init_done !== 1'b1 && cnt < 5000) begin
      tick;
      cnt++;
    end
    total++; if (cnt != 2049) begin bad++; $display("FAIL rescrub_cycles got=%0d exp=2049", cnt); end
    read_word(11'h123);
    total++; if (bus.rdat !== 32'h0 || bus.rsbe !== 1'b0 || bus.rdbe !== 1'b0) begin
      bad++; $display("FAIL rescrub_data got rdat=%h sbe=%b dbe=%b exp 0/0/0", bus.rdat, bus.rsbe, bus.rdbe);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    t_cw  = '0;
    test_reset;
    test_write_read;
    test_back_to_back;
    test_collision;
`ifdef MDMA_RAM_ERR_INJECT_EN
    test_inject;
`endif
    test_decoder;
    test_reset_midway;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdma_32bx2048_32bwe_ram.md
Name: mdma_32bx2048_32bwe_ram

Overview:
- Memory-side responder for the mdma 32bx2048 RAM interface. Implements the s modport: a 2048x32 simple-dual-port SRAM with SECDED ECC.
- Serves the descriptor/data buffers driven by the mdma engine through the m modport.
- Reports corrected single-bit errors on rsbe and detected double-bit errors on rdbe.
- Runs a post-reset scrub that zero-fills the array so every location holds a valid codeword.

Parameters:
- DEPTH, 2048, number of words; must be a power of 2.
- AW, 11, address width, equal to log2(DEPTH).
- DW, 32, data width.
- CW, 7, check bits: 6 Hamming bits plus 1 overall parity bit; codeword is 39 bits.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- wadr  in  AW  write address.
- wen  in  1  write enable; full 32-bit word write.
- wdat  in  DW  write data.
- ren  in  1  read enable.
- radr  in  AW  read address.
- rdat  out  DW  read data; corrected data when the error is correctable.
- rsbe  out  1  single-bit error corrected; pulse aligned with rdat.
- rdbe  out  1  double-bit error detected; pulse aligned with rdat.
- init_done  out  1  high once the post-reset scrub has finished.

Behaviour:
- Reset values: rdat=0, rsbe=0, rdbe=0, init_done=0. Read pipeline valid bits are cleared. Array contents are not reset.
- FSM has two states, INIT and RUN.
  - INIT is entered on reset. A counter scrub_adr walks 0..DEPTH-1 and writes the codeword for all-zero data (39'h0), one location per cycle.
  - At scrub_adr==DEPTH-1, the FSM moves to RUN and init_done rises on the next cycle. Total scrub time is DEPTH cycles after reset release.
  - In INIT, wen and ren are ignored: no array write, and no read response (rsbe=rdbe=0, rdat holds).
  - When rst_n asserts mid-scrub or mid-read, the FSM returns to INIT immediately, drops in-flight reads and restarts the scrub from address 0.
- Write path (RUN): when wen=1 at a clk edge, mem[wadr] <= ecc_enc(wdat) in that cycle.
- Read path (RUN), fixed latency of 2 cycles:
  - Cycle N: ren=1 is sampled.
  - Cycle N+1: the raw codeword mem[radr] and a valid bit are registered.
  - Cycle N+2: the decoded rdat, rsbe and rdbe are registered outputs.
  - Back-to-back reads are supported, one per cycle, fully pipelined.
- rdat holds its last value when no read completes. rsbe and rdbe are 0 on any cycle without a completing read.
- Read/write collision: ren and wen in the same cycle with radr==wadr returns the old data (read-first); the new data is visible on the next read.
- Decode rules:
  - Syndrome 0 and parity ok: no error.
  - Parity mismatch: single-bit error. Flip the indicated bit and set rsbe. A syndrome of 0 with parity mismatch means the error is in the parity bit itself; data is unchanged and rsbe is still set.
  - Syndrome nonzero and parity ok: double-bit error. rdat carries the uncorrected data bits and rdbe is set.
  - rsbe and rdbe are never both 1.
- The responder never writes corrected data back to the array.
- Out-of-range addresses cannot occur because DEPTH equals 2^AW.

Optional Feature:
- Macro MDMA_RAM_ERR_INJECT_EN.
- When defined, the block adds inputs inj_sbe (1 bit) and inj_dbe (1 bit), both sampled with wen.
  - inj_sbe=1: the stored codeword has bit 0 inverted.
  - inj_dbe=1: bits 0 and 1 are inverted.
  - Both asserted: inj_dbe wins.
  - Scrub writes are never corrupted.
- When not defined, the ports do not exist and encoding is always clean.

Decomposition:
- Package mdma_ram_ecc_pkg contains:
  - Constants: DW, CW, CWW=39.
  - Typedefs: codeword_t, syndrome_t, and an enum for the FSM states.
  - Functions: ecc_enc (32 to 39 bits) and ecc_syndrome.
- One combinational sub-module, mdma_secded_dec: takes a codeword and produces data, sbe and dbe. It is instantiated between the read pipeline stage 1 and the output registers.

Test Plan:
- Release reset, count cycles until init_done. Expect init_done=1 DEPTH+1 cycles after release, and a read of address 0x7FF gives rdat=0, rsbe=0, rdbe=0.
- Write 0xDEADBEEF to 0x123, then read 0x123. Expect rdat=0xDEADBEEF exactly 2 cycles after ren, with no error flags.
- Issue 4 back-to-back reads of addresses 0..3 preloaded with 0x11,0x22,0x33,0x44. Expect rdat to show them in order on consecutive cycles N+2..N+5.
- Same cycle: wen to 0x010 with 0xA5A5A5A5, ren of 0x010 (previous contents 0x5). Expect rdat=0x5; the next read returns 0xA5A5A5A5.
- With MDMA_RAM_ERR_INJECT_EN: write 0xCAFEF00D to 0x055 with inj_sbe=1, then read it. Expect rdat=0xCAFEF00D and a one-cycle rsbe pulse. Repeat with inj_dbe=1 and expect rdbe=1, rsbe=0.
- Assert rst_n low while reads are in flight and scrub_adr=0x200. Expect outputs cleared immediately, no stale rsbe/rdbe, init_done low, and the scrub restarting from address 0.
